hci_tcdm_bank_responder: RTL and testbench
==========================================

# hci_tcdm_bank_responder

Memory-side responder for the word-interleaved HCI memory ports: one independent single-ported TCDM bank per port. It accepts per-bank req/add/wen/be/data, grants requests, and returns read data one cycle after grant. Optional LFSR-driven grant stalls exercise back-pressure. It sits below the HWPE interconnect's NB_OUT_CHAN output ports, as the SRAM bank array in standalone clusters and as the bank model in interconnect benches.

## Interface
- NB_BANKS, 8, number of banks/ports; power of two, ≥ 1
- DW, 32, data width per bank
- BW, 8, bits per byte-enable lane; DW/BW lanes
- AWM, 12, word-address bits per bank; depth 2^AWM words
- STALL_EN, 0, 1 = enable random grant withholding
- MAX_STALL, 4, consecutive stalled cycles after which grant is forced; ≥ 1
- LFSR_SEED, 16'hACE1, base seed, XORed with bank index
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous soft clear of LFSRs, stall counters and response regs (memory untouched)
- stall_thr_i  in  8  stall threshold; 0 = never stall
- req_i  in  NB_BANKS  per-bank request
- gnt_o  out  NB_BANKS  per-bank grant
- add_i  in  NB_BANKS×32  byte address; only bits [AWM+1:2] used
- wen_i  in  NB_BANKS  1 = read, 0 = write
- be_i  in  NB_BANKS×(DW/BW)  byte enables (writes only)
- data_i  in  NB_BANKS×DW  write data
- r_data_o  out  NB_BANKS×DW  read data
- r_valid_o  out  NB_BANKS  response valid, one pulse per granted request

## Operation
- Banks fully independent; no cross-bank arbitration, no ordering between banks.
- Stall decision per bank: stall_b = STALL_EN && lfsr_b[7:0] < stall_thr_i && stall_cnt_b < MAX_STALL. gnt_o[b] = req_i[b] & ~stall_b. Combinational from registered state and req_i only; no path from add/data/wen to gnt.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle. Seed = LFSR_SEED ^ b; zero seed replaced by 16'h0001. STALL_EN=0: LFSR and counter logic may be removed.
- stall_cnt_b: increments (saturating at MAX_STALL) on req & ~gnt; cleared on grant or req low. Guarantees a grant within MAX_STALL+1 cycles of a held request.
- Granted write: mem[add[AWM+1:2]] updated at the clock edge, only lanes with be set.
- Granted read: r_data_o[b] ← mem[word] at the edge.
- Granted write: r_data_o[b] holds its previous value.
- r_valid_o[b] ← req & gnt for reads and writes alike.
- Address bits above AWM+1 and bits [1:0] ignored (aliasing by design).
- Reset: r_valid_o = 0, r_data_o = 0, LFSRs = seeds, stall_cnt = 0. Memory not reset; contents undefined.
- clear_i: same values as reset, applied synchronously. A grant in the same cycle as clear_i still writes memory, but produces no r_valid.
- Reset or clear during an outstanding response drops that response.

## Timing
- Grant: same cycle as req when not stalled.
- Read latency: exactly 1 cycle, grant edge to r_valid/r_data.
- Back-to-back grants every cycle per bank.
- Read of an address written in the previous cycle returns the new data.
- Read and write in the same cycle cannot occur (single port).
- r_valid_o is a 1-cycle pulse, no response back-pressure.
- Requester may drop req while stalled; no state beyond stall_cnt retained.

## Structure
- hci_package: LFSR width, tap constant, reset seed default, stall-threshold width.
- Sub-module hci_lfsr_stall: LFSR, stall counter and stall_b generation; one instance per bank.
- Memory as a per-bank generate array of behavioural reg arrays, swappable for SRAM macros behind the same port list.

## Test plan
- STALL_EN=0, bank 3: write 32'hDEADBEEF at add 0x40 with be=4'hF, then read 0x40 → gnt same cycle; r_valid 1 cycle later; r_data=32'hDEADBEEF.
- Partial write: 32'h11223344 at 0x10, then be=4'b0101 data 32'hAABBCCDD, read → 32'h11BB33DD.
- All 8 banks request every cycle for 100 cycles, random reads/writes → 100 r_valid pulses per bank; data matches scoreboard.
- STALL_EN=1, stall_thr_i=8'hFF, MAX_STALL=4, req held → gnt exactly on the 5th cycle; stall_cnt returns to 0.
- Reset asserted the cycle after a granted read → r_valid_o stays 0; r_data_o=0.
- clear_i pulse mid-stream → LFSRs back to seeds; stall pattern repeats cycle-identically versus post-reset.

Source files
------------

// File: rtl/hci_tcdm_bank_responder_pkg.sv
// Shared constants for the TCDM bank responder: LFSR geometry, default seed,
// stall-threshold width and the LFSR step/seed helpers.
package hci_tcdm_bank_responder_pkg;

    localparam int          LFSR_W        = 16;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    localparam int          STALL_THR_W   = 8;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1
    function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [LFSR_W-1:0] base,
                                                    input logic [LFSR_W-1:0] idx);
        logic [LFSR_W-1:0] s;
        s = base ^ idx;
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/hci_tcdm_bank_responder_lfsr_stall.sv
// Per-bank grant-stall generator: free-running LFSR plus a consecutive-stall
// counter that bounds how long a held request can be withheld.
module hci_tcdm_bank_responder_lfsr_stall
    import hci_tcdm_bank_responder_pkg::*;
#(
    parameter bit          STALL_EN  = 1'b0,
    parameter int          MAX_STALL = 4,
    parameter logic [15:0] SEED      = LFSR_SEED_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [STALL_THR_W-1:0] stall_thr_i,
    input  logic                   req,
    output logic                   stall
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STALL);

    if (STALL_EN) begin : g_stall
        logic [LFSR_W-1:0] lfsr;
        logic [CNT_W-1:0]  stall_cnt;

        assign stall = (lfsr[7:0] < stall_thr_i) && (stall_cnt < CNT_MAX);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                lfsr      <= SEED;
                stall_cnt <= '0;
            end else if (clear_i) begin
                lfsr      <= SEED;
                stall_cnt <= '0;
            end else begin
                lfsr <= lfsr_next(lfsr);
                // stall already implies stall_cnt < CNT_MAX, so this saturates
                if (req && stall) stall_cnt <= stall_cnt + 1'b1;
                else              stall_cnt <= '0;
            end
        end
    end else begin : g_no_stall
        logic unused;
        assign unused = ^{clk_i, rst_ni, clear_i, stall_thr_i, req};
        assign stall  = 1'b0;
    end

endmodule

// File: rtl/hci_tcdm_bank_responder.sv
// Array of independent single-ported TCDM banks: same-cycle grant (with
// optional random stalls), byte-masked writes, one-cycle read responses.
module hci_tcdm_bank_responder
    import hci_tcdm_bank_responder_pkg::*;
#(
    parameter int          NB_BANKS  = 8,
    parameter int          DW        = 32,
    parameter int          BW        = 8,
    parameter int          AWM       = 12,
    parameter bit          STALL_EN  = 1'b0,
    parameter int          MAX_STALL = 4,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic [STALL_THR_W-1:0]       stall_thr_i,
    input  logic [NB_BANKS-1:0]          req_i,
    output logic [NB_BANKS-1:0]          gnt_o,
    input  logic [NB_BANKS*32-1:0]       add_i,
    input  logic [NB_BANKS-1:0]          wen_i,
    input  logic [NB_BANKS*(DW/BW)-1:0]  be_i,
    input  logic [NB_BANKS*DW-1:0]       data_i,
    output logic [NB_BANKS*DW-1:0]       r_data_o,
    output logic [NB_BANKS-1:0]          r_valid_o
);

    localparam int LANES = DW / BW;

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        logic [DW-1:0]  mem [2**AWM];
        logic [AWM-1:0] word;
        logic           stall;

        assign word = add_i[b*32+2 +: AWM];

        // Byte offset and bits above the bank depth alias onto the same word
        if (AWM < 30) begin : g_unused_hi
            logic unused;
            assign unused = ^{add_i[b*32 +: 2], add_i[b*32+AWM+2 +: 30-AWM]};
        end else begin : g_unused_lo
            logic unused;
            assign unused = ^add_i[b*32 +: 2];
        end

        hci_tcdm_bank_responder_lfsr_stall #(
            .STALL_EN  (STALL_EN),
            .MAX_STALL (MAX_STALL),
            .SEED      (lfsr_seed(LFSR_SEED, 16'(b)))
        ) i_stall (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i),
            .stall_thr_i (stall_thr_i),
            .req         (req_i[b]),
            .stall       (stall)
        );

        assign gnt_o[b] = req_i[b] & ~stall;

        // Memory is deliberately not reset; writes still land during clear_i
        always_ff @(posedge clk_i) begin
            if (gnt_o[b] && !wen_i[b]) begin
                for (int l = 0; l < LANES; l++) begin
                    if (be_i[b*LANES+l]) mem[word][l*BW +: BW] <= data_i[b*DW+l*BW +: BW];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid_o[b]         <= 1'b0;
                r_data_o[b*DW +: DW] <= '0;
            end else if (clear_i) begin
                r_valid_o[b]         <= 1'b0;
                r_data_o[b*DW +: DW] <= '0;
            end else begin
                r_valid_o[b] <= gnt_o[b];
                if (gnt_o[b] && wen_i[b]) r_data_o[b*DW +: DW] <= mem[word];
            end
        end
    end

endmodule

// File: tb/tb_hci_tcdm_bank_responder.sv
// Self-checking bench: behavioural bank/stall model compared every cycle,
// plus directed literal checks for the key scenarios.
module tb_hci_tcdm_bank_responder;

    localparam int NB = 8;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         clear;
    logic [7:0]   stall_thr;
    logic [NB-1:0]    req;
    logic [NB-1:0]    gnt;
    logic [NB*32-1:0] add;
    logic [NB-1:0]    wen;
    logic [NB*4-1:0]  be;
    logic [NB*32-1:0] data;
    logic [NB*32-1:0] r_data;
    logic [NB-1:0]    r_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hci_tcdm_bank_responder #(
        .NB_BANKS(NB), .DW(32), .BW(8), .AWM(12),
        .STALL_EN(1'b1), .MAX_STALL(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .stall_thr_i(stall_thr),
        .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen), .be_i(be),
        .data_i(data), .r_data_o(r_data), .r_valid_o(r_valid)
    );

    // ---------------- behavioural model ----------------
    logic [15:0] m_lfsr [NB];
    int          m_run  [NB];   // consecutive cycles this bank has been stalled
    logic        m_rv   [NB];
    logic [31:0] m_rd   [NB];
    logic [31:0] m_mem  [int];
    int          rv_count [NB];

    task automatic chk(input string nm, input int b, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s bank%0d got %h expected %h at %0t", nm, b, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_lfsr[b] = 16'hACE1 ^ 16'(b);
            m_run[b]  = 0;
            m_rv[b]   = 1'b0;
            m_rd[b]   = 32'h0;
        end
    endtask

    always @(negedge clk) begin
        logic        g;
        logic [15:0] l;
        int          key;
        logic [31:0] w;
        if (!rst_ni) model_reset();
        for (int b = 0; b < NB; b++) begin
            l = m_lfsr[b];
            g = req[b] && !((int'(l[7:0]) < int'(stall_thr)) && (m_run[b] < 4));
            chk("model_gnt", b, 32'(gnt[b]), 32'(g));
            chk("model_rvalid", b, 32'(r_valid[b]), 32'(m_rv[b]));
            chk("model_rdata", b, r_data[b*32 +: 32], m_rd[b]);
            if (m_rv[b]) rv_count[b]++;
            if (rst_ni) begin
                key = b * 4096 + int'(add[b*32+2 +: 12]);
                if (g) begin
                    if (wen[b]) m_rd[b] = m_mem.exists(key) ? m_mem[key] : 32'h0;
                    else begin
                        w = m_mem.exists(key) ? m_mem[key] : 32'h0;
                        for (int k = 0; k < 4; k++)
                            if (be[b*4+k]) w[k*8 +: 8] = data[b*32+k*8 +: 8];
                        m_mem[key] = w;
                    end
                end
                m_rv[b]  = g;
                m_run[b] = (req[b] && !g) ? ((m_run[b] < 4) ? m_run[b] + 1 : 4) : 0;
                m_lfsr[b] = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                if (clear) begin
                    m_lfsr[b] = 16'hACE1 ^ 16'(b);
                    m_run[b]  = 0;
                    m_rv[b]   = 1'b0;
                    m_rd[b]   = 32'h0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0; wen = '0; be = '0; add = '0; data = '0;
    endtask

    task automatic setb(input int b, input logic r, input logic [31:0] a, input logic w,
                        input logic [3:0] bb, input logic [31:0] d);
        req[b] = r; add[b*32 +: 32] = a; wen[b] = w; be[b*4 +: 4] = bb; data[b*32 +: 32] = d;
    endtask

    logic [NB-1:0] rec_a [20];
    logic [NB-1:0] rec_b [20];
    logic [4:0]    exp_pat;

    initial begin
        rst_ni = 1'b0; clear = 1'b0; stall_thr = 8'h00;
        idle();
        model_reset();
        for (int b = 0; b < NB; b++) rv_count[b] = 0;
        step(); step();
        @(negedge clk);
        chk("reset_rvalid", 0, 32'(r_valid), 32'h0);
        for (int b = 0; b < NB; b++) chk("reset_rdata", b, r_data[b*32 +: 32], 32'h0);
        step();
        rst_ni = 1'b1;
        step();

        // full write then read, bank 3
        setb(3, 1, 32'h40, 0, 4'hF, 32'hDEADBEEF);
        @(negedge clk); chk("wr_gnt_same_cycle", 3, 32'(gnt[3]), 32'h1);
        step();
        setb(3, 1, 32'h40, 1, 4'h0, 32'h0);
        @(negedge clk); chk("wr_rvalid", 3, 32'(r_valid[3]), 32'h1);
        step();
        idle();
        @(negedge clk);
        chk("rd_rvalid", 3, 32'(r_valid[3]), 32'h1);
        chk("rd_data", 3, r_data[3*32 +: 32], 32'hDEADBEEF);
        step();
        @(negedge clk); chk("rvalid_pulse", 3, 32'(r_valid[3]), 32'h0);

        // partial write, then read from an aliased address
        step();
        setb(3, 1, 32'h10, 0, 4'hF, 32'h11223344); step();
        setb(3, 1, 32'h10, 0, 4'b0101, 32'hAABBCCDD); step();
        setb(3, 1, 32'hFFFF_C013, 1, 4'h0, 32'h0); step();
        idle();
        @(negedge clk); chk("partial_write", 3, r_data[3*32 +: 32], 32'h11BB33DD);

        // write in the clear cycle still lands, but gives no response
        step();
        clear = 1'b1;
        setb(2, 1, 32'h20, 0, 4'hF, 32'hCAFEF00D); step();
        clear = 1'b0; idle();
        @(negedge clk); chk("clear_no_rvalid", 2, 32'(r_valid[2]), 32'h0);
        step();
        setb(2, 1, 32'h20, 1, 4'h0, 32'h0); step();
        idle();
        @(negedge clk); chk("clear_write_kept", 2, r_data[2*32 +: 32], 32'hCAFEF00D);

        // prewrite words 0..15 on every bank, then 100 cycles of random traffic
        for (int i = 0; i < 16; i++) begin
            for (int b = 0; b < NB; b++) setb(b, 1, 32'(i * 4), 0, 4'hF, $urandom);
            step();
        end
        idle(); step();
        for (int b = 0; b < NB; b++) rv_count[b] = 0;
        for (int i = 0; i < 100; i++) begin
            for (int b = 0; b < NB; b++)
                setb(b, 1, ($urandom & 32'hFFFF_C003) | 32'($urandom_range(0, 15) * 4),
                     1'($urandom), 4'($urandom), $urandom);
            step();
        end
        idle();
        @(negedge clk); #1;
        for (int b = 0; b < NB; b++) chk("random_rvalid_count", b, 32'(rv_count[b]), 32'd100);

        // reset right after a granted read drops the response
        step();
        setb(3, 1, 32'h40, 1, 4'h0, 32'h0); step();
        rst_ni = 1'b0; idle();
        @(negedge clk);
        chk("reset_drop_rvalid", 3, 32'(r_valid[3]), 32'h0);
        chk("reset_drop_rdata", 3, r_data[3*32 +: 32], 32'h0);
        step(); step();
        rst_ni = 1'b1;

        // stall pattern after reset, then the same after a clear
        stall_thr = 8'h80;
        for (int i = 0; i < 20; i++) begin
            for (int b = 0; b < NB; b++) setb(b, 1, 32'h0, 1, 4'h0, 32'h0);
            @(negedge clk); rec_a[i] = gnt;
            step();
        end
        idle();
        for (int i = 0; i < 7; i++) step();
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            for (int b = 0; b < NB; b++) setb(b, 1, 32'h0, 1, 4'h0, 32'h0);
            @(negedge clk); rec_b[i] = gnt;
            step();
        end
        idle();
        for (int i = 0; i < 20; i++) chk("clear_repeats_reset", i, 32'(rec_b[i]), 32'(rec_a[i]));

        // threshold 0xFF: held request is granted on exactly the 5th cycle
        stall_thr = 8'hFF;
        clear = 1'b1; step(); clear = 1'b0;
        exp_pat = 5'b10000;
        for (int i = 0; i < 6; i++) begin
            setb(0, 1, 32'h0, 1, 4'h0, 32'h0);
            @(negedge clk);
            chk("max_stall_gnt", i, 32'(gnt[0]), (i < 5) ? 32'(exp_pat[i]) : 32'h0);
            step();
        end
        idle(); stall_thr = 8'h00;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
